// File: rtl/ahb_addr_gen_pkg.sv
// Shared types and default parameters for the AHB address generator.
package ahb_addr_gen_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned ADDR_STEP_DFLT = 4;
  localparam int unsigned CNT_W_DFLT     = 20;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ahb_addr_chan.sv
// One address channel: address register, word counter, fresh flag and
// ready-pulse generation, with an external gate for throttling.
module ahb_addr_chan
  import ahb_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DFLT,
  parameter int unsigned CNT_W     = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  addr_t            base,
  input  logic             active,
  input  logic             run,
  input  logic             inc,
  input  logic             gate,
  input  logic [CNT_W-1:0] num,
  output addr_t            addr,
  output logic             ready,
  output logic [CNT_W-1:0] cnt_nxt_c
);

  addr_t            addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fresh_q, fresh_d;
  logic             ready_q, ready_d;
  logic             adv_c;

  // Post-strobe count; kept apart so the write gate can use it without a loop.
  always_comb begin
    adv_c     = run & inc & (cnt_q < num);
    cnt_nxt_c = cnt_q + CNT_W'(adv_c);
  end

  // Address advance, fresh tracking and ready pulse decision.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    ready_d = 1'b0;
    if (load) begin
      addr_d  = base;
      cnt_d   = '0;
      fresh_d = 1'b1;
    end else if (active) begin
      cnt_d = cnt_nxt_c;
      // The final strobe leaves the address on the last valid word.
      if (adv_c && (cnt_nxt_c < num)) begin
        addr_d  = addr_q + 32'(ADDR_STEP);
        fresh_d = 1'b1;
      end
      ready_d = fresh_d & gate & (cnt_nxt_c < num);
      fresh_d = fresh_d & ~ready_d;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
      ready_q <= ready_d;
    end
  end

  assign addr  = addr_q;
  assign ready = ready_q;

endmodule

// File: rtl/ahb_addr_gen.sv
// Read/write address stream generator feeding the AHB master.
module ahb_addr_gen
  import ahb_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DFLT,
  parameter int unsigned CNT_W     = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  addr_t            rbase,
  input  addr_t            wbase,
  input  logic [CNT_W-1:0] num_words,
  input  logic             inc_raddr,
  input  logic             inc_waddr,
  output addr_t            raddr,
  output addr_t            waddr,
  output logic             raddr_ready,
  output logic             waddr_ready,
  output logic             stop,
  output logic             frame_done
);

  state_e           state_q, state_d;
  logic             start_q;
  logic [CNT_W-1:0] num_q, num_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             launch_c, load_c, active_c, run_c, wgate_c;
  logic [CNT_W-1:0] rcnt_nxt_c, wcnt_nxt_c;

  assign launch_c = start & ~start_q;
  assign load_c   = launch_c & ((state_q == IDLE) | (state_q == DONE));
  assign active_c = (state_q == LOAD) | (state_q == RUN);
  assign run_c    = (state_q == RUN);
  // Writes never overtake reads: gate on post-update counts.
  assign wgate_c  = wcnt_nxt_c < rcnt_nxt_c;

  // Next-state and status flag logic.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    stop_d  = stop_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_c) begin
          state_d = LOAD;
          num_d   = num_words;
          stop_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (num_q == '0) begin
          state_d = DONE;
          stop_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (rcnt_nxt_c == num_q) stop_d = 1'b1;
        if (wcnt_nxt_c == num_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      num_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      num_q   <= num_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  ahb_addr_chan #(.ADDR_STEP(ADDR_STEP), .CNT_W(CNT_W)) u_rd (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load_c),
    .base     (rbase),
    .active   (active_c),
    .run      (run_c),
    .inc      (inc_raddr),
    .gate     (1'b1),
    .num      (num_q),
    .addr     (raddr),
    .ready    (raddr_ready),
    .cnt_nxt_c(rcnt_nxt_c)
  );

  ahb_addr_chan #(.ADDR_STEP(ADDR_STEP), .CNT_W(CNT_W)) u_wr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load_c),
    .base     (wbase),
    .active   (active_c),
    .run      (run_c),
    .inc      (inc_waddr),
    .gate     (wgate_c),
    .num      (num_q),
    .addr     (waddr),
    .ready    (waddr_ready),
    .cnt_nxt_c(wcnt_nxt_c)
  );

  assign stop       = stop_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ahb_addr_gen.sv
// Bench for ahb_addr_gen: directed table, reset corner cases, random frames.
module tb_ahb_addr_gen;

  localparam int unsigned CNT_W = 20;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic [31:0]      rbase, wbase;
  logic [CNT_W-1:0] num_words;
  logic             inc_raddr, inc_waddr;
  logic [31:0]      raddr, waddr;
  logic             raddr_ready, waddr_ready, stop, frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ahb_addr_gen dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .rbase      (rbase),
    .wbase      (wbase),
    .num_words  (num_words),
    .inc_raddr  (inc_raddr),
    .inc_waddr  (inc_waddr),
    .raddr      (raddr),
    .waddr      (waddr),
    .raddr_ready(raddr_ready),
    .waddr_ready(waddr_ready),
    .stop       (stop),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [31:0] rb;
    logic [31:0] wb;
    int          num;
    int          rlo, rhi, wlo, whi;
    logic [31:0] exp_ra;
    logic [31:0] exp_wa;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " raddr"}, raddr, 32'h0);
    chk({tag, " waddr"}, waddr, 32'h0);
    chk({tag, " raddr_ready"}, 32'(raddr_ready), 32'h0);
    chk({tag, " waddr_ready"}, 32'(waddr_ready), 32'h0);
    chk({tag, " stop"}, 32'(stop), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Acts as the master for one frame and checks every cycle against an
  // event-time model: read pulse k comes one cycle after read strobe k-1
  // (two cycles after launch for k=0); write pulse k additionally waits
  // for read strobe k.
  task automatic run_frame(input logic [31:0] rb, input logic [31:0] wb, input int num,
                           input int rlo, input int rhi, input int wlo, input int whi,
                           input int abort_at, output int nr, output int nw);
    int  rs_t[64];
    int  ws_t[64];
    int  lc, rs, ws, rp, wp, rdl, wdl, settle, budget, c, er, ew;
    bit  rpend, wpend, exp_rr, exp_wr, exp_stop, exp_done, finished;
    rs = 0; ws = 0; rp = 0; wp = 0; rdl = 0; wdl = 0; settle = 0;
    rpend = 0; wpend = 0; finished = 0; nr = 0; nw = 0;
    budget = 40 + num * 12;
    rbase = rb; wbase = wb; num_words = CNT_W'(num);
    start = 0;
    inc_raddr = 1'($urandom_range(0, 1));
    inc_waddr = 1'($urandom_range(0, 1));
    tick();
    start = 1;
    lc = cyc;
    tick();
    start = 0; inc_raddr = 0; inc_waddr = 0;
    for (int k = 0; k < budget; k++) begin
      c = cyc;
      er = (rp == 0) ? lc + 2 : rs_t[rp-1] + 1;
      exp_rr = (rp < num) && (rs == rp) && (c == er);
      exp_wr = 0;
      if ((wp < num) && (ws == wp) && (rs > wp)) begin
        ew = (wp == 0) ? lc + 2 : ws_t[wp-1] + 1;
        if (rs_t[wp] + 1 > ew) ew = rs_t[wp] + 1;
        exp_wr = (c == ew);
      end
      exp_stop = (num == 0) ? (c >= lc + 2) : (rs == num);
      exp_done = (num == 0) ? (c >= lc + 2) : (ws == num);
      chk("raddr_ready", 32'(raddr_ready), 32'(exp_rr));
      chk("waddr_ready", 32'(waddr_ready), 32'(exp_wr));
      chk("stop", 32'(stop), 32'(exp_stop));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      nr += int'(raddr_ready);
      nw += int'(waddr_ready);
      if (exp_rr) begin
        chk("raddr on pulse", raddr, rb + 32'(4 * rp));
        rp++; rpend = 1; rdl = $urandom_range(rlo, rhi);
      end
      if (exp_wr) begin
        chk("waddr on pulse", waddr, wb + 32'(4 * wp));
        wp++; wpend = 1; wdl = $urandom_range(wlo, whi);
      end
      if (ws == num) settle++;
      if (settle > 3) begin
        finished = 1;
        break;
      end
      inc_raddr = 0;
      if (rpend) begin
        if (rdl == 0) begin
          inc_raddr = 1; rs_t[rs] = c; rs++; rpend = 0;
        end else rdl--;
      end else if (rs == num) inc_raddr = 1'($urandom_range(0, 1));
      inc_waddr = 0;
      if (wpend) begin
        if (wdl == 0) begin
          inc_waddr = 1; ws_t[ws] = c; ws++; wpend = 0;
        end else wdl--;
      end else if (ws == num) inc_waddr = 1'($urandom_range(0, 1));
      start = (ws < num) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_at > 0 && rs == abort_at) begin
        tick();
        inc_raddr = 0; inc_waddr = 0; start = 0;
        n_rst = 0;
        #1;
        chk_idle_zero("in reset");
        tick();
        tick();
        n_rst = 1;
        repeat (3) begin
          tick();
          chk_idle_zero("after reset");
        end
        return;
      end
      tick();
    end
    inc_raddr = 0; inc_waddr = 0; start = 0;
    if (!finished) chk("frame timeout", 32'h1, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran out of time at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nr, nw, num;
    logic [31:0] rb, wb;
    n_rst = 0; start = 0; rbase = '0; wbase = '0; num_words = '0;
    inc_raddr = 0; inc_waddr = 0;
    tick();
    tick();
    chk_idle_zero("reset");

    // Master init strobe right after reset release must be ignored.
    n_rst = 1; inc_raddr = 1; inc_waddr = 1;
    tick();
    inc_raddr = 0; inc_waddr = 0;
    chk_idle_zero("init strobe");
    tick();
    chk_idle_zero("idle hold");

    vecs[0] = '{32'h0000_1000, 32'h0000_8000, 3, 1, 1, 0, 0, 32'h0000_1008, 32'h0000_8008, 3};
    vecs[1] = '{32'hFFFF_FFFC, 32'h0000_0100, 2, 0, 2, 0, 2, 32'h0000_0000, 32'h0000_0104, 2};
    vecs[2] = '{32'h0000_2000, 32'h0000_3000, 0, 0, 1, 0, 1, 32'h0000_2000, 32'h0000_3000, 0};
    vecs[3] = '{32'h0000_0010, 32'hFFFF_FFF8, 4, 0, 0, 0, 0, 32'h0000_001C, 32'h0000_0004, 4};
    vecs[4] = '{32'h0000_0040, 32'h0000_0080, 1, 2, 3, 1, 3, 32'h0000_0040, 32'h0000_0080, 1};
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].rb, vecs[i].wb, vecs[i].num, vecs[i].rlo, vecs[i].rhi,
                vecs[i].wlo, vecs[i].whi, 0, nr, nw);
      chk("vec final raddr", raddr, vecs[i].exp_ra);
      chk("vec final waddr", waddr, vecs[i].exp_wa);
      chk("vec read pulses", 32'(nr), 32'(vecs[i].exp_pulses));
      chk("vec write pulses", 32'(nw), 32'(vecs[i].exp_pulses));
    end

    // Reset after two reads, then a clean relaunch from new bases.
    run_frame(32'h0000_5000, 32'h0000_6000, 6, 0, 2, 0, 2, 2, nr, nw);
    run_frame(32'h0000_A000, 32'h0000_B000, 4, 0, 2, 0, 2, 0, nr, nw);
    chk("relaunch final raddr", raddr, 32'h0000_A00C);
    chk("relaunch final waddr", waddr, 32'h0000_B00C);
    chk("relaunch read pulses", 32'(nr), 32'd4);
    chk("relaunch write pulses", 32'(nw), 32'd4);

    for (int i = 0; i < 10; i++) begin
      rb  = (i % 3 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      wb  = $urandom & 32'hFFFF_FFFC;
      num = $urandom_range(0, 12);
      run_frame(rb, wb, num, 0, 3, 0, 3, 0, nr, nw);
      chk("rand final raddr", raddr, (num > 0) ? rb + 32'(4 * (num - 1)) : rb);
      chk("rand final waddr", waddr, (num > 0) ? wb + 32'(4 * (num - 1)) : wb);
      chk("rand read pulses", 32'(nr), 32'(num));
      chk("rand write pulses", 32'(nw), 32'(num));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_addr_gen.md
Name: ahb_addr_gen

Overview:
Address-generation stage directly upstream of the AHB master. It produces the read address stream (source greyscale image) and the write address stream (edge-detected result), one word per transfer. It consumes the master's inc_raddr/inc_waddr strobes and returns raddr_ready/waddr_ready pulses. It asserts stop once the read stream is exhausted, so the master no longer issues dummy reads.

Parameters:
ADDR_STEP, 4, byte increment per word transfer
CNT_W, 20, width of the word counters (max 2^CNT_W-1 words per frame)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  level; rising edge seen in IDLE/DONE launches a frame
rbase  in  32  read (source) base byte address, sampled on launch
wbase  in  32  write (result) base byte address, sampled on launch
num_words  in  CNT_W  words per frame, sampled on launch
inc_raddr  in  1  master consumed current raddr; advance
inc_waddr  in  1  master consumed current waddr; advance
raddr  out  32  current read address
waddr  out  32  current write address
raddr_ready  out  1  1-cycle pulse: raddr holds a new valid address
waddr_ready  out  1  1-cycle pulse: waddr holds a new valid address
stop  out  1  all reads issued; master suppresses further reads
frame_done  out  1  level; all reads and writes issued, held until next launch

Behaviour:
- Clock and reset: one clock clk; reset n_rst is asynchronous and active-low. All state is registered.
- Reset values: raddr=0, waddr=0, raddr_ready=0, waddr_ready=0, stop=0, frame_done=0, state=IDLE, rcnt=0, wcnt=0, start_q=0.
- Launch is start & !start_q, where start_q is the registered start.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on launch. Latch rbase, wbase and num_words. Set rcnt=wcnt=0, stop=0 and frame_done=0.
- LOAD (1 cycle):
  - raddr=rbase, waddr=wbase.
  - If num_words==0, go to DONE with stop=1 and frame_done=1, and issue no ready pulses.
  - Otherwise go to RUN.
  - raddr_ready pulses on the first RUN cycle, i.e. one cycle after raddr is valid.
- RUN, read channel:
  - On inc_raddr with rcnt<num_words: rcnt++ and raddr+=ADDR_STEP.
  - If the new rcnt<num_words, raddr_ready pulses on the next cycle.
  - If the new rcnt==num_words, stop=1 from the next cycle, raddr holds its last value, and there is no pulse.
- RUN, write channel:
  - Writes may never overtake reads.
  - waddr_ready pulses only when the current waddr is fresh (not yet pulsed) and wcnt<rcnt.
  - A fresh waddr blocked by wcnt>=rcnt is held. It pulses in the cycle after rcnt advances past wcnt.
  - On inc_waddr with wcnt<num_words: wcnt++ and waddr+=ADDR_STEP.
- RUN -> DONE when wcnt==num_words, with frame_done=1 registered.
- DONE: outputs hold. A launch re-enters LOAD.
- inc_raddr/inc_waddr in IDLE, LOAD or DONE are ignored. This covers the master's post-reset init strobe, which fires both together.
- A strobe after its counter has reached num_words is ignored; no counter overrun.
- inc_raddr and inc_waddr in the same cycle are both processed. The write gating uses the post-update rcnt.
- A strobe arriving in the same cycle as a ready pulse is legal.
- Address arithmetic is unsigned 32-bit modulo 2^32; wrap past 0xFFFF_FFFC is silent.
- Counters are CNT_W bits and compare against num_words only, so they never wrap.
- Launch while in RUN or LOAD is ignored.
- Reset mid-frame returns everything to reset values immediately. No pulse is emitted in the cycle after reset release.

Decomposition:
- Package ahb_addr_gen_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN, DONE);
  - ADDR_STEP and CNT_W defaults;
  - the addr_t (32-bit) typedef.
- Sub-module ahb_addr_chan holds one address register, one counter, the fresh flag and the ready-pulse generation. It has a gate input for write throttling. It is instantiated twice: the read copy with gate tied to 1, the write copy with gate = wcnt<rcnt.

Test Plan:
- Reset, then n_rst=1 with inc_raddr=inc_waddr=1 for 1 cycle in IDLE -> raddr=waddr=0, no ready pulses, counters stay 0.
- rbase=0x1000, wbase=0x8000, num_words=3, start; master strobes each read one cycle after its pulse:
  - raddr steps 0x1000 -> 0x1004 -> 0x1008;
  - exactly 3 raddr_ready pulses;
  - stop=1 one cycle after the third inc_raddr.
- Same frame, strobe inc_waddr eagerly -> first waddr_ready appears only after the first inc_raddr; waddr pulse count never exceeds raddr strobe count; waddr reaches 0x8008 and frame_done=1 after the 3rd inc_waddr.
- Simultaneous inc_raddr and inc_waddr with rcnt=wcnt+1 -> both advance in that cycle; the next waddr_ready pulses because the post-update rcnt exceeds wcnt.
- rbase=0xFFFF_FFFC, num_words=2 -> second raddr=0x0000_0000; num_words=0 -> frame_done=1 and stop=1 two cycles after launch, zero pulses.
- Assert n_rst=0 mid-frame after 2 reads, release, relaunch with num_words=4 -> clean restart from the new bases, 4 read pulses, no stale pulse.
